// File: rtl/reset_sequencer.sv
// Staged reset controller: async-assert/sync-release of rst, PLL lock
// filtering, reset stretch, soft reset and ordered per-domain release.
module reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int NUM_OUT        = 3,
    parameter int LOCK_FILTER    = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGE_GAP      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               soft_rst_req,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               done,
    output logic [1:0]         cause
);

    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int SW = $clog2(STRETCH_CYCLES + 1);
    localparam int GW = $clog2(STAGE_GAP + 1);

    localparam logic [2:0] HOLD      = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] STRETCH   = 3'd2;
    localparam logic [2:0] RELEASE   = 3'd3;
    localparam logic [2:0] RUN       = 3'd4;

    localparam logic [1:0] CAUSE_EXT  = 2'd0;
    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_SOFT = 2'd2;

    logic [SYNC_STAGES-1:0] rst_pipe;
    logic [SYNC_STAGES-1:0] lock_pipe;
    logic                   rst_sync;
    logic                   lock_s;

    logic [2:0]         state;
    logic [FW-1:0]      filt_cnt;
    logic [SW-1:0]      str_cnt;
    logic [GW-1:0]      gap_cnt;
    logic [NUM_OUT-1:0] rel_next;
    logic               lock_lost;
    logic               soft_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_pipe  <= '1;
            lock_pipe <= '0;
        end else begin
            rst_pipe  <= {rst_pipe[SYNC_STAGES-2:0], 1'b0};
            lock_pipe <= {lock_pipe[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign rst_sync = rst_pipe[SYNC_STAGES-1];
    assign lock_s   = lock_pipe[SYNC_STAGES-1];

    // Shifting left drops the lowest still-asserted bit, so release
    // order is fixed and released bits can never come back one by one.
    assign rel_next = rst_out << 1;

    assign lock_lost = !lock_s &&
        (state == STRETCH || state == RELEASE || state == RUN);
    assign soft_hit = soft_rst_req &&
        (state == RELEASE || state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HOLD;
            rst_out  <= '1;
            done     <= 1'b0;
            cause    <= CAUSE_EXT;
            filt_cnt <= '0;
            str_cnt  <= '0;
            gap_cnt  <= '0;
        end else if (lock_lost) begin
            state    <= WAIT_LOCK;
            rst_out  <= '1;
            done     <= 1'b0;
            cause    <= CAUSE_LOCK;
            filt_cnt <= '0;
        end else if (soft_hit) begin
            state   <= STRETCH;
            rst_out <= '1;
            done    <= 1'b0;
            cause   <= CAUSE_SOFT;
            str_cnt <= SW'(STRETCH_CYCLES - 1);
        end else begin
            case (state)
                HOLD: begin
                    if (!rst_sync) begin
                        state    <= WAIT_LOCK;
                        filt_cnt <= '0;
                    end
                end
                WAIT_LOCK: begin
                    if (!lock_s) begin
                        filt_cnt <= '0;
                    end else if (filt_cnt == FW'(LOCK_FILTER - 1)) begin
                        state   <= STRETCH;
                        str_cnt <= SW'(STRETCH_CYCLES - 1);
                    end else begin
                        filt_cnt <= filt_cnt + 1'b1;
                    end
                end
                STRETCH: begin
                    if (str_cnt == '0) begin
                        rst_out <= rel_next;
                        gap_cnt <= GW'(STAGE_GAP - 1);
                        if (rel_next == '0) begin
                            state <= RUN;
                            done  <= 1'b1;
                        end else begin
                            state <= RELEASE;
                        end
                    end else begin
                        str_cnt <= str_cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    if (gap_cnt == '0) begin
                        rst_out <= rel_next;
                        gap_cnt <= GW'(STAGE_GAP - 1);
                        if (rel_next == '0) begin
                            state <= RUN;
                            done  <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                RUN: ;
                default: state <= HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default build and a NUM_OUT=1,
// STAGE_GAP=1, SYNC_STAGES=3 build share stimulus; one is checked at a time.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic [2:0] ro_a;
    logic       ro_b;
    logic       dn_a;
    logic       dn_b;
    logic [1:0] cs_a;
    logic [1:0] cs_b;

    always #5 clk = ~clk;

    reset_sequencer u_a (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .rst_out      (ro_a),
        .done         (dn_a),
        .cause        (cs_a)
    );

    reset_sequencer #(
        .SYNC_STAGES (3),
        .NUM_OUT     (1),
        .STAGE_GAP   (1)
    ) u_b (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .rst_out      (ro_b),
        .done         (dn_b),
        .cause        (cs_b)
    );

    typedef struct {
        int         at;
        logic [2:0] ro;
        logic       dn;
    } vec_t;

    vec_t tbl[$];

    int         sel;
    int         ss, no, lf, sc, sg;
    logic [2:0] all1;
    int         checks = 0;
    int         errors = 0;

    logic [2:0] ro;
    logic       dn;
    logic [1:0] cs;

    always_comb begin
        ro = (sel != 0) ? {2'b00, ro_b} : ro_a;
        dn = (sel != 0) ? dn_b : dn_a;
        cs = (sel != 0) ? cs_b : cs_a;
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL cfg%0d %s: got %0h expected %0h",
                     sel, nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expired(input string nm);
        checks++;
        errors++;
        $display("FAIL cfg%0d %s: timed out", sel, nm);
    endtask

    task automatic wait_bit0(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ro[0] !== 1'b0 && n < 400);
        if (ro[0] !== 1'b0) expired("wait_bit0");
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (dn !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        if (dn !== 1'b1) expired("wait_done");
    endtask

    task automatic assert_rst_async(input string nm);
        #3 rst = 1'b1;
        #1;
        chk({nm, "_ro"}, ro, all1);
        chk({nm, "_done"}, dn, 0);
        chk({nm, "_cause"}, cs, 0);
    endtask

    task automatic do_reset(input logic lock);
        pll_locked = lock;
        tick();
        assert_rst_async("rst");
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic pulse_soft();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
    endtask

    // Called on the sample where bit 0 has just dropped.
    task automatic staged(input string nm);
        chk({nm, "_done_b0"}, dn, (no == 1));
        for (int k = 1; k < no; k++) begin
            repeat (sg - 1) tick();
            chk({nm, "_hold"}, ro[k], 1);
            tick();
            chk({nm, "_drop"}, ro[k], 0);
            chk({nm, "_done"}, dn, (k == no - 1));
        end
    endtask

    function automatic logic [2:0] low_below(input int k);
        logic [2:0] m;
        m = all1;
        for (int j = 0; j < 3; j++)
            if (j < k) m[j] = 1'b0;
        return m;
    endfunction

    // Release edges are nominal +0/+1, so samples straddle each edge.
    task automatic build_table();
        int n;
        vec_t v;
        n = ss + lf + sc;
        tbl.delete();
        for (int k = 0; k < no; k++) begin
            v.at = n + k * sg - 1;
            v.ro = low_below(k);
            v.dn = 1'b0;
            tbl.push_back(v);
            v.at = n + k * sg + 1;
            v.ro = low_below(k + 1);
            v.dn = (k == no - 1);
            tbl.push_back(v);
        end
    endtask

    task automatic run_all();
        int n;
        int cur;

        // 1: power-up release
        do_reset(1'b1);
        build_table();
        cur = 0;
        foreach (tbl[i]) begin
            while (cur < tbl[i].at) begin
                tick();
                cur++;
            end
            chk($sformatf("t1_ro@%0d", cur), ro, tbl[i].ro);
            chk($sformatf("t1_dn@%0d", cur), dn, tbl[i].dn);
            chk($sformatf("t1_cs@%0d", cur), cs, 0);
        end

        // 2: lock filter rejects short lock pulses
        do_reset(1'b0);
        repeat (ss + 2) tick();
        for (int r = 0; r < 5; r++) begin
            pll_locked = 1'b1;
            for (int c = 0; c < 3; c++) begin
                tick();
                chk("t2_glitch_hi", ro, all1);
            end
            pll_locked = 1'b0;
            tick();
            chk("t2_glitch_lo", ro, all1);
        end
        chk("t2_cause", cs, 0);
        pll_locked = 1'b1;
        wait_bit0(n);
        chk("t2_lat", n, ss + lf + sc);
        staged("t2");

        // 3: lock loss in RUN
        pll_locked = 1'b0;
        for (int i = 1; i <= ss + 1; i++) begin
            tick();
            if (i == ss) begin
                chk("t3_run_ro", ro, 0);
                chk("t3_run_dn", dn, 1);
            end
            if (i == ss + 1) begin
                chk("t3_loss_ro", ro, all1);
                chk("t3_loss_dn", dn, 0);
                chk("t3_loss_cs", cs, 1);
            end
            if (i == 2) pll_locked = 1'b1;
        end
        wait_bit0(n);
        chk("t3_lat", ss - 1 + n, ss + lf + sc);
        staged("t3");

        // 4: soft reset, ignored in STRETCH, honoured mid-RELEASE
        pulse_soft();
        chk("t4_ro", ro, all1);
        chk("t4_cs", cs, 2);
        chk("t4_dn", dn, 0);
        repeat (4) tick();
        pulse_soft();
        wait_bit0(n);
        chk("t4_str_lat", n + 5, sc);
        pulse_soft();
        chk("t4_mid_ro", ro, all1);
        chk("t4_mid_cs", cs, 2);
        wait_bit0(n);
        chk("t4_mid_lat", n, sc);
        staged("t4");
        chk("t4_sticky", cs, 2);

        // 5: lock loss wins over a same-cycle soft request
        pll_locked = 1'b0;
        repeat (ss) tick();
        pulse_soft();
        pll_locked = 1'b1;
        chk("t5_ro", ro, all1);
        chk("t5_cs", cs, 1);
        chk("t5_dn", dn, 0);
        wait_bit0(n);
        chk("t5_lat", n, ss + lf + sc);
        staged("t5");

        // 6: async rst mid-STRETCH and mid-RELEASE
        pulse_soft();
        repeat (5) tick();
        assert_rst_async("t6_str");
        tick();
        rst = 1'b0;
        wait_done();
        pulse_soft();
        wait_bit0(n);
        assert_rst_async("t6_rel");
        tick();
        rst = 1'b0;
        wait_done();
        chk("t6_cs_end", cs, 0);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            sel = s;
            if (s == 0) begin
                ss = 2; no = 3; lf = 4; sc = 16; sg = 8;
                all1 = 3'b111;
            end else begin
                ss = 3; no = 1; lf = 4; sc = 16; sg = 1;
                all1 = 3'b001;
            end
            run_all();
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
